ber_rx_sync: RTL and testbench

- Parametrised receive-side successor to the PRBS9+BPSK+RC link.
- Takes the oversampled filter output and decimates it at a selectable phase offset. It then slices the BPSK bit from the sign.
- Aligns a local PRBS9 reference to the received stream by automatic latency search, then counts bits and errors.
- Sits after filtro_fir. Shares the baud strobe from control and drives the BER status LEDs.

---
 rtl/ber_rx_sync_pkg.sv | 24 ++
 rtl/ber_rx_sync_prbs9_ref.sv | 63 ++++++
 rtl/ber_rx_sync.sv | 150 +++++++++++++++
 tb/tb_ber_rx_sync.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ber_rx_sync_pkg.sv
// Shared definitions for the BER receive synchroniser: PRBS9 taps/seed,
// FSM state encoding and a width helper.
package ber_rx_sync_pkg;

  // x^9 + x^5 + 1, Fibonacci form: feedback = lfsr[8] ^ lfsr[4]
  localparam int PRBS9_TAP_A = 8;
  localparam int PRBS9_TAP_B = 4;
  localparam logic [8:0] PRBS9_DEFAULT_SEED = 9'h1AA;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } sync_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ber_rx_sync_prbs9_ref.sv
// Local PRBS9 reference: generator plus a baud-spaced delay line whose
// tap is chosen by the latency under test.
module prbs9
  import ber_rx_sync_pkg::*;
#(
  parameter logic [8:0] SEED = PRBS9_DEFAULT_SEED
) (
  input  logic clock,
  input  logic reset,
  input  logic i_advance,
  output logic o_bit
);

  logic [8:0] r_lfsr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else if (i_advance) begin
      r_lfsr <= {r_lfsr[7:0], r_lfsr[PRBS9_TAP_A] ^ r_lfsr[PRBS9_TAP_B]};
    end
  end

  assign o_bit = r_lfsr[8];

endmodule

module prbs9_ref
  import ber_rx_sync_pkg::*;
#(
  parameter logic [8:0] SEED    = PRBS9_DEFAULT_SEED,
  parameter int         MAX_LAT = 16,
  parameter int         NB_LAT  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_advance,
  input  logic [NB_LAT-1:0] i_latency,
  output logic              o_ref_bit
);

  logic               w_prbs_bit;
  logic [MAX_LAT-1:0] r_delay;

  prbs9 #(.SEED(SEED)) u_prbs9 (
    .clock    (clock),
    .reset    (reset),
    .i_advance(i_advance),
    .o_bit    (w_prbs_bit)
  );

  // r_delay[0] is the bit emitted at the most recent baud strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_delay <= '0;
    end else if (i_advance) begin
      r_delay <= {r_delay[MAX_LAT-2:0], w_prbs_bit};
    end
  end

  assign o_ref_bit = r_delay[i_latency];

endmodule

// File: rtl/ber_rx_sync.sv
// Decimating BPSK slicer with automatic PRBS9 latency search, lock tracking
// and saturating bit/error counters.
module ber_rx_sync
  import ber_rx_sync_pkg::*;
#(
  parameter int         OS       = 4,
  parameter int         NB_DATA  = 8,
  parameter int         NB_COUNT = 64,
  parameter logic [8:0] SEED     = PRBS9_DEFAULT_SEED,
  parameter int         MAX_LAT  = 16,
  parameter int         SYNC_WIN = 511,
  parameter int         LOSS_THR = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_enable,
  input  logic                        i_valid,
  input  logic signed [NB_DATA-1:0]   i_sample,
  input  logic [clog2(OS)-1:0]        i_offset,
  input  logic                        i_clear,
  output logic                        o_rx_bit,
  output logic                        o_locked,
  output logic [clog2(MAX_LAT)-1:0]   o_latency,
  output logic [NB_COUNT-1:0]         o_bit_count,
  output logic [NB_COUNT-1:0]         o_error_count,
  output logic                        o_ber_zero
);

  localparam int NB_OFS = clog2(OS);
  localparam int NB_LAT = clog2(MAX_LAT);
  localparam int NB_WIN = clog2(SYNC_WIN);
  localparam int NB_ERR = clog2(LOSS_THR + 1);
  localparam logic [NB_WIN-1:0] WIN_LAST  = NB_WIN'(SYNC_WIN - 1);
  localparam logic [NB_ERR-1:0] ERR_LIMIT = NB_ERR'(LOSS_THR);
  localparam logic [NB_LAT-1:0] LAT_LAST  = NB_LAT'(MAX_LAT - 1);

  logic signed [NB_DATA-1:0] r_buf [OS];
  logic                      r_rx_bit;
  logic                      r_cmp;
  logic [NB_OFS-1:0]         r_offset;
  sync_state_t               r_state;
  logic [NB_LAT-1:0]         r_latency;
  logic [NB_WIN-1:0]         r_win_cnt;
  logic [NB_ERR-1:0]         r_win_err;
  logic [NB_COUNT-1:0]       r_bit_count;
  logic [NB_COUNT-1:0]       r_error_count;

  logic              w_advance;
  logic              w_ref_bit;
  logic              w_mismatch;
  logic              w_ofs_change;
  logic [NB_LAT-1:0] w_lat_next;
  logic [NB_ERR-1:0] w_err_next;

  // i_valid is a one-clock baud strobe; it only counts while i_enable is high
  assign w_advance    = i_enable & i_valid;
  assign w_mismatch   = r_rx_bit ^ w_ref_bit;
  assign w_ofs_change = i_enable & (i_offset != r_offset);
  assign w_lat_next   = (r_latency == LAT_LAST) ? '0 : r_latency + NB_LAT'(1);
  assign w_err_next   = r_win_err + NB_ERR'(w_mismatch);

  prbs9_ref #(.SEED(SEED), .MAX_LAT(MAX_LAT), .NB_LAT(NB_LAT)) u_ref (
    .clock    (clock),
    .reset    (reset),
    .i_advance(w_advance),
    .i_latency(r_latency),
    .o_ref_bit(w_ref_bit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < OS; i++) r_buf[i] <= '0;
      r_rx_bit <= 1'b0;
      r_cmp    <= 1'b0;
      r_offset <= '0;
    end else if (i_enable) begin
      r_buf[0] <= i_sample;
      for (int i = 1; i < OS; i++) r_buf[i] <= r_buf[i-1];
      if (i_valid) r_rx_bit <= r_buf[i_offset][NB_DATA-1];
      r_cmp    <= i_valid;
      r_offset <= i_offset;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_SEARCH;
      r_latency     <= '0;
      r_win_cnt     <= '0;
      r_win_err     <= '0;
      r_bit_count   <= '0;
      r_error_count <= '0;
    end else if (i_enable) begin
      if (w_ofs_change) begin
        r_state   <= ST_SEARCH;
        r_latency <= '0;
        r_win_cnt <= '0;
        r_win_err <= '0;
      end else if (r_cmp) begin
        case (r_state)
          ST_SEARCH: begin
            if (w_mismatch) begin
              r_latency <= w_lat_next;
              r_win_cnt <= '0;
            end else if (r_win_cnt == WIN_LAST) begin
              r_state       <= ST_LOCKED;
              r_win_cnt     <= '0;
              r_win_err     <= '0;
              r_bit_count   <= '0;
              r_error_count <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + NB_WIN'(1);
            end
          end
          ST_LOCKED: begin
            if (r_bit_count != '1) r_bit_count <= r_bit_count + NB_COUNT'(1);
            if (w_mismatch && (r_error_count != '1))
              r_error_count <= r_error_count + NB_COUNT'(1);
            if (w_err_next == ERR_LIMIT) begin
              r_state   <= ST_SEARCH;
              r_latency <= w_lat_next;
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else if (r_win_cnt == WIN_LAST) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + NB_WIN'(1);
              r_win_err <= w_err_next;
            end
          end
          default: r_state <= ST_SEARCH;
        endcase
      end
      // Clear overrides any count made by a coincident compare strobe
      if (i_clear) begin
        r_bit_count   <= '0;
        r_error_count <= '0;
      end
    end
  end

  assign o_rx_bit      = r_rx_bit;
  assign o_locked      = (r_state == ST_LOCKED);
  assign o_latency     = r_latency;
  assign o_bit_count   = r_bit_count;
  assign o_error_count = r_error_count;
  assign o_ber_zero    = o_locked & (r_error_count == '0);

endmodule

// File: tb/tb_ber_rx_sync.sv
// Directed bench for ber_rx_sync: loopback with a 3-baud channel delay,
// lock loss, error injection, clear, freeze, offset change, async reset.
module tb_ber_rx_sync;

  logic              clock;
  logic              reset;
  logic              i_enable;
  logic              i_valid;
  logic signed [7:0] i_sample;
  logic [1:0]        i_offset;
  logic              i_clear;
  logic              o_rx_bit;
  logic              o_locked;
  logic [3:0]        o_latency;
  logic [63:0]       o_bit_count;
  logic [63:0]       o_error_count;
  logic              o_ber_zero;

  int checks;
  int errors;

  logic [8:0] tx_lfsr;
  logic [2:0] tx_hist;

  ber_rx_sync dut (
    .clock        (clock),
    .reset        (reset),
    .i_enable     (i_enable),
    .i_valid      (i_valid),
    .i_sample     (i_sample),
    .i_offset     (i_offset),
    .i_clear      (i_clear),
    .o_rx_bit     (o_rx_bit),
    .o_locked     (o_locked),
    .o_latency    (o_latency),
    .o_bit_count  (o_bit_count),
    .o_error_count(o_error_count),
    .o_ber_zero   (o_ber_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tx_reset();
    tx_lfsr = 9'h1AA;
    tx_hist = 3'b000;
  endtask

  // Transmit-side PRBS9 followed by a 3-baud channel delay
  task automatic tx_next(output logic b);
    b       = tx_hist[2];
    tx_hist = {tx_hist[1:0], tx_lfsr[8]};
    tx_lfsr = {tx_lfsr[7:0], tx_lfsr[8] ^ tx_lfsr[4]};
  endtask

  task automatic tick(input logic signed [7:0] s, input logic v, input logic clr);
    i_sample = s;
    i_valid  = v;
    i_clear  = clr;
    @(posedge clock);
    #1;
  endtask

  // One baud: symbol held for 4 clocks, strobe on the last; optional clear
  // on the first clock, which is the compare cycle of the previous strobe
  task automatic baud(input logic flip, input logic clr);
    logic b;
    tx_next(b);
    b = b ^ flip;
    for (int c = 0; c < 4; c++) tick(b ? -8'sd64 : 8'sd64, c == 3, clr && (c == 0));
    i_valid = 1'b0;
    i_clear = 1'b0;
  endtask

  task automatic acquire(input string tag);
    int n;
    n = 0;
    while (!o_locked && n < 5 * 511) begin
      baud(1'b0, 1'b0);
      n++;
    end
    check_eq({tag, "_locked"}, 64'(o_locked), 64'd1);
    check_eq({tag, "_latency"}, 64'(o_latency), 64'd3);
  endtask

  initial begin
    logic b;
    int   n;
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    i_enable = 1'b1;
    i_valid  = 1'b0;
    i_sample = '0;
    i_offset = 2'd2;
    i_clear  = 1'b0;
    tx_reset();
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_rx_bit", 64'(o_rx_bit), 64'd0);
    check_eq("rst_locked", 64'(o_locked), 64'd0);
    check_eq("rst_latency", 64'(o_latency), 64'd0);
    check_eq("rst_bits", o_bit_count, 64'd0);
    check_eq("rst_errs", o_error_count, 64'd0);
    check_eq("rst_ber_zero", 64'(o_ber_zero), 64'd0);
    reset = 1'b0;

    acquire("acq");
    check_eq("acq_bits", o_bit_count, 64'd0);
    check_eq("acq_ber_zero", 64'(o_ber_zero), 64'd1);

    // All symbols inverted straight after lock: 1 good compare, then 64 bad
    n = 0;
    while (o_locked && n < 2 * 511) begin
      baud(1'b1, 1'b0);
      n++;
    end
    check_eq("loss_locked", 64'(o_locked), 64'd0);
    check_eq("loss_bauds", 64'(n), 64'd65);
    check_eq("loss_latency", 64'(o_latency), 64'd4);
    check_eq("loss_bits", o_bit_count, 64'd65);
    check_eq("loss_errs", o_error_count, 64'd64);
    repeat (3) baud(1'b0, 1'b0);
    check_eq("hold_bits", o_bit_count, 64'd65);
    check_eq("hold_errs", o_error_count, 64'd64);
    acquire("reacq");

    repeat (10000) baud(1'b0, 1'b0);
    check_eq("clean_bits", o_bit_count, 64'd10000);
    check_eq("clean_errs", o_error_count, 64'd0);
    check_eq("clean_ber_zero", 64'(o_ber_zero), 64'd1);
    check_eq("clean_locked", 64'(o_locked), 64'd1);

    baud(1'b0, 1'b1);
    check_eq("clr_bits", o_bit_count, 64'd0);
    check_eq("clr_errs", o_error_count, 64'd0);
    baud(1'b0, 1'b0);
    check_eq("clr_restart", o_bit_count, 64'd1);
    for (int k = 2; k < 5000; k++) baud((k % 100) == 50, 1'b0);
    baud(1'b0, 1'b0);
    check_eq("inj_bits", o_bit_count, 64'd5000);
    check_eq("inj_errs", o_error_count, 64'd50);
    check_eq("inj_locked", 64'(o_locked), 64'd1);
    check_eq("inj_ber_zero", 64'(o_ber_zero), 64'd0);

    i_enable = 1'b0;
    for (int c = 0; c < 24; c++) tick(-8'sd64, (c % 4) == 3, 1'b0);
    check_eq("frz_bits", o_bit_count, 64'd5000);
    check_eq("frz_errs", o_error_count, 64'd50);
    check_eq("frz_locked", 64'(o_locked), 64'd1);
    i_enable = 1'b1;
    baud(1'b0, 1'b0);
    check_eq("frz_resume", o_bit_count, 64'd5001);

    i_offset = 2'd0;
    tx_next(b);
    tick(b ? -8'sd64 : 8'sd64, 1'b0, 1'b0);
    check_eq("ofs_locked", 64'(o_locked), 64'd0);
    check_eq("ofs_latency", 64'(o_latency), 64'd0);
    check_eq("ofs_bits", o_bit_count, 64'd5001);
    tick(b ? -8'sd64 : 8'sd64, 1'b0, 1'b0);
    tick(b ? -8'sd64 : 8'sd64, 1'b0, 1'b0);
    tick(b ? -8'sd64 : 8'sd64, 1'b1, 1'b0);
    i_valid = 1'b0;
    acquire("ofs");

    repeat (5) baud(1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_locked", 64'(o_locked), 64'd0);
    check_eq("arst_latency", 64'(o_latency), 64'd0);
    check_eq("arst_bits", o_bit_count, 64'd0);
    check_eq("arst_errs", o_error_count, 64'd0);
    check_eq("arst_rx_bit", 64'(o_rx_bit), 64'd0);
    check_eq("arst_ber_zero", 64'(o_ber_zero), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tx_reset();
    acquire("arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
